// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart TX-side controllers: FSM state encodings and timeout default.
package uart_tx_arbiter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational rotate-priority pick: first asserted request after last_grant, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             any_req,
  output logic [IDX_W-1:0] winner
);

  logic found;

  always_comb begin
    any_req = |req;
    winner  = '0;
    found   = 1'b0;
    // Offset i walks the ring starting just after last_grant; j matches that slot.
    for (int unsigned i = 1; i <= N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && req[j] && (j == (32'(last_grant) + i) % N)) begin
          winner = IDX_W'(j);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the uart TX FIFO write port among NREQ sources,
// with an idle timeout that revokes ownership from a stalled source.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned DBIT    = 8,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned TO_W    = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [DBIT-1:0]      w_data,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 abort_tick
);

  logic [0:0]       state_q, state_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             abort_q, abort_d;

  logic             any_req;
  logic [IDX_W-1:0] winner;
  logic             in_xfer, valid_g, last_g, wr;
  logic [DBIT-1:0]  data_g;

  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_comb begin
    in_xfer = (state_q == ST_XFER);
    valid_g = req_valid[grant_idx_q];
    last_g  = req_last[grant_idx_q];
    data_g  = req_data[grant_idx_q*DBIT +: DBIT];
    wr      = in_xfer & valid_g & ~tx_full;

    req_ready   = (in_xfer && !tx_full) ? (NREQ'(1) << grant_idx_q) : '0;
    wr_uart     = wr;
    w_data      = wr ? data_g : '0;
    grant_valid = grant_valid_q;
    grant_idx   = grant_idx_q;
    abort_tick  = abort_q;
  end

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    abort_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d       = ST_XFER;
          grant_valid_d = 1'b1;
          grant_idx_d   = winner;
          cnt_d         = '0;
        end
      end
      default: begin
        if (wr) begin
          cnt_d = '0;
          if (last_g) begin
            state_d       = ST_IDLE;
            grant_valid_d = 1'b0;
            last_grant_d  = grant_idx_q;
          end
        end else if (!valid_g) begin
          // The TIMEOUT-th consecutive idle cycle revokes the grant.
          if (cnt_q == TO_W'(TIMEOUT - 1)) begin
            state_d       = ST_IDLE;
            grant_valid_d = 1'b0;
            last_grant_d  = grant_idx_q;
            cnt_d         = '0;
            abort_d       = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      last_grant_q  <= IDX_W'(NREQ - 1);
      cnt_q         <= '0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      abort_q       <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued packet sources, hand-computed grant order and timing.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        tx_full, wr_uart;
  logic [7:0]  w_data;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic        abort_tick;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;

  logic [7:0] qd [4][$];
  logic       ql [4][$];
  bit         hold [4];
  logic [7:0] wlog [$];
  int         glog [$];
  int         clog [$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ    (4),
    .IDX_W   (2),
    .DBIT    (8),
    .TIMEOUT (64),
    .TO_W    (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_full     (tx_full),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .abort_tick  (abort_tick)
  );

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (qd[i].size() > 0 && !hold[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = qd[i][0];
        req_last[i]        = ql[i][0];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic push(input int src, input logic [7:0] d, input logic l);
    qd[src].push_back(d);
    ql[src].push_back(l);
  endtask

  // Log this cycle's write, retire accepted bytes, advance one clock and re-drive sources.
  task automatic tick();
    if (wr_uart) begin
      wlog.push_back(w_data);
      glog.push_back(int'(grant_idx));
      clog.push_back(cyc);
    end
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    tx_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      qd[i].delete();
      ql[i].delete();
      hold[i] = 1'b0;
    end
    wlog.delete();
    glog.delete();
    clog.delete();
    drive();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    #1;
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < 4; i++) if (qd[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_until_empty(input string name, input int max_cycles);
    int n = 0;
    while ((pending() || grant_valid) && n < max_cycles) begin
      tick();
      n++;
    end
    if (n >= max_cycles) begin
      total++;
      $display("FAIL %s: timed out after %0d cycles, required drain", name, n);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    tx_full   = 1'b0;
    req_valid = 4'hF;
    req_last  = 4'hF;
    req_data  = 32'hDEADBEEF;
    #2;
    total++;
    if ({wr_uart, req_ready, grant_valid, grant_idx, abort_tick, w_data} !== 17'h0)
      $display("FAIL reset_outputs: got wr=%b rdy=%b gv=%b gi=%0d ab=%b wd=%h, required all 0",
               wr_uart, req_ready, grant_valid, grant_idx, abort_tick, w_data);
    else pass_cnt++;
  endtask

  task automatic test_single_packet();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    do_reset();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    drive();
    #1;
    total++;
    if (grant_valid !== 1'b0 || wr_uart !== 1'b0)
      $display("FAIL single_cycle0: gv=%b wr=%b, required 0 0", grant_valid, wr_uart);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (grant_valid !== 1'b1 || grant_idx !== 2'd0 || wr_uart !== 1'b1 || w_data !== exp_b[k])
        $display("FAIL single_byte%0d: gv=%b gi=%0d wr=%b wd=%h, required 1 0 1 %h",
                 k, grant_valid, grant_idx, wr_uart, w_data, exp_b[k]);
      else pass_cnt++;
    end
    tick();
    total++;
    if (grant_valid !== 1'b0 || wr_uart !== 1'b0)
      $display("FAIL single_release: gv=%b wr=%b, required 0 0", grant_valid, wr_uart);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_w [8];
    int         exp_g [8];
    exp_w = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1};
    exp_g = '{1, 1, 3, 3, 0, 0, 1, 1};
    do_reset();
    push(1, 8'hA0, 1'b0); push(1, 8'hA1, 1'b1);
    push(3, 8'hB0, 1'b0); push(3, 8'hB1, 1'b1);
    drive();
    #1;
    run_until_empty("rr_round1", 40);
    push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b1);
    push(1, 8'hD0, 1'b0); push(1, 8'hD1, 1'b1);
    drive();
    #1;
    run_until_empty("rr_round2", 40);
    total++;
    if (wlog.size() != 8) $display("FAIL rr_count: got %0d writes, required 8", wlog.size());
    else begin
      pass_cnt++;
      for (int k = 0; k < 8; k++) begin
        total++;
        if (wlog[k] !== exp_w[k] || glog[k] != exp_g[k])
          $display("FAIL rr_write%0d: data=%h src=%0d, required data=%h src=%0d",
                   k, wlog[k], glog[k], exp_w[k], exp_g[k]);
        else pass_cnt++;
      end
      total++;
      if (clog[2] - clog[1] != 2)
        $display("FAIL rr_bubble: gap=%0d cycles, required 2", clog[2] - clog[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
    drive();
    #1;
    tick();
    tick();
    tx_full = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (wr_uart !== 1'b0 || req_ready !== 4'h0 || abort_tick !== 1'b0 || grant_valid !== 1'b1)
        $display("FAIL bp_stall%0d: wr=%b rdy=%b ab=%b gv=%b, required 0 0 0 1",
                 k, wr_uart, req_ready, abort_tick, grant_valid);
      else pass_cnt++;
      tick();
    end
    tx_full = 1'b0;
    #1;
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'h22 || req_ready !== 4'b0100)
      $display("FAIL bp_resume: wr=%b wd=%h rdy=%b, required 1 22 0100", wr_uart, w_data, req_ready);
    else pass_cnt++;
    run_until_empty("bp_drain", 20);
    total++;
    if (wlog.size() != 3 || wlog[0] !== 8'h21 || wlog[1] !== 8'h22 || wlog[2] !== 8'h23)
      $display("FAIL bp_sequence: got %0d writes, required 21 22 23", wlog.size());
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_reset();
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
    push(1, 8'h30, 1'b1);
    drive();
    #1;
    tick();
    total++;
    if (wr_uart !== 1'b1 || w_data !== 8'h10 || grant_idx !== 2'd0)
      $display("FAIL to_first: wr=%b wd=%h gi=%0d, required 1 10 0", wr_uart, w_data, grant_idx);
    else pass_cnt++;
    hold[0] = 1'b1;
    tick();
    while (cyc < 67) begin
      total++;
      if (abort_tick !== (cyc == 66) || wr_uart !== 1'b0 || grant_valid !== (cyc != 66))
        $display("FAIL to_cycle%0d: ab=%b wr=%b gv=%b, required ab=%b wr=0 gv=%b",
                 cyc, abort_tick, wr_uart, grant_valid, cyc == 66, cyc != 66);
      else pass_cnt++;
      tick();
    end
    total++;
    if (abort_tick !== 1'b0 || grant_idx !== 2'd1 || wr_uart !== 1'b1 || w_data !== 8'h30)
      $display("FAIL to_regrant: ab=%b gi=%0d wr=%b wd=%h, required 0 1 1 30",
               abort_tick, grant_idx, wr_uart, w_data);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(2, 8'h61, 1'b0); push(2, 8'h62, 1'b0); push(2, 8'h63, 1'b1);
    drive();
    #1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++;
    if ({wr_uart, req_ready, grant_valid, grant_idx, abort_tick, w_data} !== 17'h0)
      $display("FAIL rstmid_outputs: wr=%b rdy=%b gv=%b gi=%0d ab=%b wd=%h, required all 0",
               wr_uart, req_ready, grant_valid, grant_idx, abort_tick, w_data);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      qd[i].delete();
      ql[i].delete();
    end
    push(0, 8'h50, 1'b1);
    push(2, 8'h60, 1'b1);
    drive();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    tick();
    total++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd0 || w_data !== 8'h50)
      $display("FAIL rstmid_regrant: gv=%b gi=%0d wd=%h, required 1 0 50", grant_valid, grant_idx, w_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(i, 8'h70 + 8'(i), 1'b1);
      push(i, 8'h80 + 8'(i), 1'b1);
    end
    drive();
    #1;
    run_until_empty("b2b_drain", 60);
    total++;
    if (wlog.size() != 8) $display("FAIL b2b_count: got %0d writes, required 8", wlog.size());
    else begin
      pass_cnt++;
      for (int k = 0; k < 8; k++) begin
        total++;
        if (glog[k] != k % 4 || wlog[k] !== ((k < 4) ? 8'h70 : 8'h80) + 8'(k % 4) ||
            (k > 0 && clog[k] - clog[k-1] != 2))
          $display("FAIL b2b_write%0d: src=%0d data=%h gap=%0d, required src=%0d gap=2",
                   k, glog[k], wlog[k], (k > 0) ? clog[k] - clog[k-1] : 2, k % 4);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
